// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - Load/store request, response and dump beat bundle for dmem_responder
interface dmem_responder_if;
    logic        dump;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dump_valid;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;

    modport slave (
        input  dump, req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               dump_valid, dump_addr, dump_data, dump_done
    );

    modport master (
        output dump, req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Data-memory responder with fixed-latency load/store and full-array dump
module dmem_responder #(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, BUSY, RESP, DUMP, DONE} stateT;

    stateT                  state, stateNext;
    logic [CW-1:0]          cnt;
    logic [IDXW-1:0]        beatIdx;
    logic                   dumpQ, dumpPending, dumpRise;
    logic                   reqWe;
    logic [2:0]             reqSize;
    logic [31:0]            reqAddr, reqWdata;
    logic [31:0]            rspData;
    logic                   rspErr;
    logic [DEPTH-1:0][31:0] mem;

    logic                   below;
    logic [29:0]            wordOff;
    logic [IDXW-1:0]        idx;
    logic                   outOfRange, badSize, misaligned, accessErr;
    logic [31:0]            curWord, loadData, storeWord, laneMask, mergedWord;
    logic [7:0]             loadByte;
    logic [15:0]            loadHalf;
    logic                   accept, commit;

    assign dumpRise = bus.dump & ~dumpQ;
    assign accept   = bus.req_valid && bus.req_ready;
    assign commit   = (state == BUSY) && (cnt == '0);

    // Word offset from the base; the borrow bit flags addresses below BASE_ADDR.
    assign {below, wordOff} = {1'b0, reqAddr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign idx              = wordOff[IDXW-1:0];

    always_comb begin
        outOfRange = below || (wordOff >= 30'(DEPTH));
        badSize    = (reqSize == 3'b011) || (reqSize == 3'b110) || (reqSize == 3'b111)
                     || (reqWe && reqSize[2]);
        misaligned = ((reqSize[1:0] == 2'b01) && reqAddr[0])
                     || ((reqSize == 3'b010) && (reqAddr[1:0] != 2'b00));
        accessErr  = outOfRange || badSize || misaligned;
        curWord    = mem[idx];

        case (reqAddr[1:0])
            2'd0:    loadByte = curWord[7:0];
            2'd1:    loadByte = curWord[15:8];
            2'd2:    loadByte = curWord[23:16];
            default: loadByte = curWord[31:24];
        endcase
        loadHalf = reqAddr[1] ? curWord[31:16] : curWord[15:0];

        case (reqSize)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadData = {24'h0, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadData = {16'h0, loadHalf};
            default: loadData = curWord;
        endcase

        // Replicate the store data across lanes and let the mask pick the target lane.
        case (reqSize[1:0])
            2'b00: begin
                laneMask  = 32'h0000_00FF << {reqAddr[1:0], 3'b000};
                storeWord = {4{reqWdata[7:0]}};
            end
            2'b01: begin
                laneMask  = reqAddr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                storeWord = {2{reqWdata[15:0]}};
            end
            default: begin
                laneMask  = 32'hFFFF_FFFF;
                storeWord = reqWdata;
            end
        endcase
        mergedWord = (curWord & ~laneMask) | (storeWord & laneMask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            beatIdx     <= '0;
            dumpQ       <= 1'b0;
            dumpPending <= 1'b0;
            reqWe       <= 1'b0;
            reqSize     <= '0;
            reqAddr     <= '0;
            reqWdata    <= '0;
            rspData     <= '0;
            rspErr      <= 1'b0;
        end else begin
            state <= stateNext;
            dumpQ <= bus.dump;

            if (accept) begin
                reqWe    <= bus.req_we;
                reqSize  <= bus.req_size;
                reqAddr  <= bus.req_addr;
                reqWdata <= bus.req_wdata;
                cnt      <= CW'(LATENCY - 1);
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (commit) begin
                rspErr  <= accessErr;
                rspData <= (accessErr || reqWe) ? 32'h0 : loadData;
            end

            // A rise during a transaction waits; in IDLE the FSM takes it directly.
            if ((state == BUSY) || (state == RESP)) begin
                if (dumpRise) dumpPending <= 1'b1;
            end else begin
                dumpPending <= 1'b0;
            end

            beatIdx <= (state == DUMP) ? beatIdx + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (commit && reqWe && !accessErr) begin
            mem[idx] <= mergedWord;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (dumpRise || dumpPending) stateNext = DUMP;
                else if (bus.req_valid)      stateNext = BUSY;
            end
            BUSY:    if (cnt == '0) stateNext = RESP;
            RESP:    if (bus.rsp_ready) stateNext = IDLE;
            DUMP:    if (beatIdx == IDXW'(DEPTH - 1)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign bus.req_ready  = rst && (state == IDLE) && !dumpPending && !dumpRise;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_rdata  = (state == RESP) ? rspData : 32'h0;
    assign bus.rsp_err    = (state == RESP) && rspErr;
    assign bus.dump_valid = (state == DUMP);
    assign bus.dump_addr  = (state == DUMP) ? BASE_ADDR + (32'(beatIdx) << 2) : 32'h0;
    assign bus.dump_data  = (state == DUMP) ? mem[beatIdx] : 32'h0;
    assign bus.dump_done  = (state == DONE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Directed self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;
    int   lastLat;
    int   acceptWait;
    logic [31:0] lastData;
    logic        lastErr;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic startReq(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acceptWait = n;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitRsp();
        lastLat = 0;
        do begin
            @(posedge clk);
            #1;
            lastLat++;
        end while (!bus.rsp_valid && lastLat < 50);
        lastData = bus.rsp_rdata;
        lastErr  = bus.rsp_err;
    endtask

    task automatic endRsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expData, input logic expErr);
        startReq(we, size, addr, wdata);
        waitRsp();
        endRsp();
        check({tag, "_lat"}, 64'(lastLat), 64'(LATENCY));
        check({tag, "_data"}, {32'h0, lastData}, {32'h0, expData});
        check({tag, "_err"}, {63'h0, lastErr}, {63'h0, expErr});
    endtask

    function automatic logic [31:0] expWord(input int i);
        case (i)
            0:       return 32'hCAFE_0000;
            4:       return 32'h80AD_BEEF;
            255:     return 32'h1234_5678;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        int n;
        int extra;
        bus.dump      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;

        #12;
        check("reset_req_ready", {63'h0, bus.req_ready}, 64'h0);
        check("reset_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
        check("reset_rsp_rdata", {32'h0, bus.rsp_rdata}, 64'h0);
        check("reset_dump", {61'h0, bus.dump_valid, bus.dump_done, bus.rsp_err}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        xact("sw_10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("lw_10",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact("sb_13",   1'b1, 3'b000, 32'h13, 32'h0000_0080, 32'h0, 1'b0);
        xact("lb_13",   1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        xact("lbu_13",  1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        xact("lw_10b",  1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        xact("lhu_12",  1'b0, 3'b101, 32'h12, 32'h0, 32'h000080AD, 1'b0);
        xact("lh_12",   1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
        xact("lh_10",   1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        xact("lb_10",   1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
        xact("lbu_11",  1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 1'b0);

        xact("lw_mis",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        xact("sh_mis",  1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 1'b1);
        xact("lw_keep", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        xact("lw_oor",  1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
        xact("sz_011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        xact("sbu_st",  1'b1, 3'b100, 32'h10, 32'hFF, 32'h0, 1'b1);
        xact("lw_keep2",1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        xact("sw_last", 1'b1, 3'b010, 32'h3FC, 32'h12345678, 32'h0, 1'b0);
        xact("lw_last", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h12345678, 1'b0);
        xact("sh_02",   1'b1, 3'b001, 32'h2, 32'hCAFE, 32'h0, 1'b0);
        xact("lw_00",   1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFE0000, 1'b0);

        // Back-pressure: response must stay frozen while rsp_ready is low
        startReq(1'b0, 3'b010, 32'h10, 32'h0);
        waitRsp();
        check("hold_lat", 64'(lastLat), 64'(LATENCY));
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", {63'h0, bus.rsp_valid}, 64'h1);
            check("hold_rdata", {32'h0, bus.rsp_rdata}, 64'h80ADBEEF);
            check("hold_req_ready", {63'h0, bus.req_ready}, 64'h0);
            @(posedge clk);
            #1;
        end
        endRsp();
        startReq(1'b0, 3'b100, 32'h13, 32'h0);
        check("next_accept_wait", 64'(acceptWait), 64'h0);
        waitRsp();
        endRsp();
        check("next_rdata", {32'h0, lastData}, 64'h80);

        // Dump requested while a load is in flight
        startReq(1'b0, 3'b010, 32'h3FC, 32'h0);
        bus.dump = 1'b1;
        waitRsp();
        check("dump_busy_lat", 64'(lastLat), 64'(LATENCY));
        check("dump_busy_rdata", {32'h0, lastData}, 64'h12345678);
        check("dump_busy_nobeat", {63'h0, bus.dump_valid}, 64'h0);
        check("dump_busy_req_ready", {63'h0, bus.req_ready}, 64'h0);
        endRsp();
        check("dump_pending_req_ready", {63'h0, bus.req_ready}, 64'h0);
        n = 0;
        while (!bus.dump_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("dump_start", 64'(n), 64'h1);
        for (int i = 0; i < DEPTH; i++) begin
            check("dump_beat", {bus.dump_valid, bus.dump_addr[30:0], bus.dump_data},
                  {1'b1, 31'(4 * i), expWord(i)});
            @(posedge clk);
            #1;
        end
        check("dump_done", {62'h0, bus.dump_done, bus.dump_valid}, 64'h2);
        extra = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (bus.dump_valid || bus.dump_done) extra++;
        end
        check("dump_no_retrigger", 64'(extra), 64'h0);
        check("dump_after_req_ready", {63'h0, bus.req_ready}, 64'h1);
        bus.dump = 1'b0;

        // Reset while a response is being presented
        startReq(1'b0, 3'b010, 32'h3FC, 32'h0);
        waitRsp();
        check("rst_resp_valid_before", {63'h0, bus.rsp_valid}, 64'h1);
        rst = 1'b0;
        #1;
        check("rst_resp_valid", {63'h0, bus.rsp_valid}, 64'h0);
        check("rst_resp_rdata", {32'h0, bus.rsp_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset while BUSY
        startReq(1'b0, 3'b010, 32'h10, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_busy_valid", {63'h0, bus.rsp_valid}, 64'h0);
        check("rst_busy_req_ready", {63'h0, bus.req_ready}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) extra++;
        end
        check("rst_busy_aborted", 64'(extra), 64'h0);
        xact("lw_10_cleared", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
        xact("lw_last_cleared", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
